commit_trace_buf: RTL and testbench

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

---
 rtl/commit_trace_buf.sv | 137 +++++++++++++
 tb/tb_commit_trace_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: captures retired-instruction records into a FIFO for a trace consumer.
//
// Ports:
//   clk, rst            sole clock; synchronous active-high reset
//   commit              one retired instruction this cycle
//   commit_instr/pc/pre_pc  retired instruction word and PC fields
//   trace_valid/ready   head-entry handshake toward the consumer
//   trace_instr/pc/pre_pc/seq/jump  head entry fields (all zero when empty)
//   commit_cnt          commits seen while running (including dropped ones)
//   drop_cnt, overflow  commits lost to a full FIFO (saturating) / sticky flag
//   level               current occupancy
//   halted, done        ebreak retired / ebreak retired and FIFO drained
module commit_trace_buf #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       commit,
   input  logic [31:0]                commit_instr,
   input  logic [63:0]                commit_pc,
   input  logic [63:0]                commit_pre_pc,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [31:0]                trace_instr,
   output logic [63:0]                trace_pc,
   output logic [63:0]                trace_pre_pc,
   output logic [63:0]                trace_seq,
   output logic                       trace_jump,
   output logic [63:0]                commit_cnt,
   output logic [31:0]                drop_cnt,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       halted,
   output logic                       done
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [31:0] Ebreak = 32'h00100073;

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   wrPtr_q, rdPtr_q;
   logic [LvlW-1:0]   level_q, level_d;
   logic [63:0]       commitCnt_q;
   logic [31:0]       dropCnt_q;
   logic              overflow_q;

   logic [31:0]       instrMem [DEPTH];
   logic [63:0]       pcMem    [DEPTH];
   logic [63:0]       prePcMem [DEPTH];
   logic [63:0]       seqMem   [DEPTH];
   logic              jumpMem  [DEPTH];

   logic capture, empty, full, pop, push, drop, jumpIn;

   always_comb begin
      capture = commit && (state_q == StRun);
      empty   = (level_q == '0);
      full    = (level_q == LvlW'(DEPTH));
      pop     = !empty && trace_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push    = capture && (!full || pop);
      drop    = capture && full && !pop;
      jumpIn  = (commit_pc != (commit_pre_pc + 64'd4));
   end

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (capture && (commit_instr == Ebreak)) state_d = StDrain;
         // Uses the post-pop level so done follows the final pop immediately.
         StDrain: if (level_d == '0) state_d = StDone;
         StDone:  state_d = StDone;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         commitCnt_q <= '0;
         dropCnt_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
         if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
         if (capture) commitCnt_q <= commitCnt_q + 64'd1;
         if (drop) begin
            if (dropCnt_q != 32'hFFFFFFFF) dropCnt_q <= dropCnt_q + 32'd1;
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset; reads are masked while empty.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         instrMem[wrPtr_q] <= commit_instr;
         pcMem[wrPtr_q]    <= commit_pc;
         prePcMem[wrPtr_q] <= commit_pre_pc;
         seqMem[wrPtr_q]   <= commitCnt_q;
         jumpMem[wrPtr_q]  <= jumpIn;
      end
   end

   always_comb begin
      trace_valid  = !empty;
      trace_instr  = empty ? 32'd0 : instrMem[rdPtr_q];
      trace_pc     = empty ? 64'd0 : pcMem[rdPtr_q];
      trace_pre_pc = empty ? 64'd0 : prePcMem[rdPtr_q];
      trace_seq    = empty ? 64'd0 : seqMem[rdPtr_q];
      trace_jump   = empty ? 1'b0  : jumpMem[rdPtr_q];
      commit_cnt   = commitCnt_q;
      drop_cnt     = dropCnt_q;
      overflow     = overflow_q;
      level        = level_q;
      halted       = (state_q != StRun);
      done         = (state_q == StDone);
   end

endmodule

// File: tb/tb_commit_trace_buf.sv
module tb_commit_trace_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        commit = 1'b0;
   logic [31:0] commit_instr = '0;
   logic [63:0] commit_pc = '0;
   logic [63:0] commit_pre_pc = '0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [31:0] trace_instr;
   logic [63:0] trace_pc, trace_pre_pc, trace_seq, commit_cnt;
   logic        trace_jump, overflow, halted, done;
   logic [31:0] drop_cnt;
   logic [3:0]  level;

   int total = 0;
   int bad = 0;

   commit_trace_buf #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .commit(commit), .commit_instr(commit_instr),
      .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc), .trace_valid(trace_valid),
      .trace_ready(trace_ready), .trace_instr(trace_instr), .trace_pc(trace_pc),
      .trace_pre_pc(trace_pre_pc), .trace_seq(trace_seq), .trace_jump(trace_jump),
      .commit_cnt(commit_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .level(level),
      .halted(halted), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; commit = 1'b0; trace_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_commit(input logic [31:0] ins, input logic [63:0] pre, input logic [63:0] pc);
      commit = 1'b1; commit_instr = ins; commit_pre_pc = pre; commit_pc = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1; commit = 1'b1; commit_instr = 32'h13; trace_ready = 1'b0;
      tick();
      rst = 1'b0; commit = 1'b0;
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", trace_valid); end
      total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level got %0d exp 0", level); end
      total++; if (commit_cnt !== 64'd0) begin bad++; $display("FAIL rst_commit_cnt got %0d exp 0", commit_cnt); end
      total++; if (drop_cnt !== 32'd0 || overflow !== 1'b0) begin bad++; $display("FAIL rst_drop got %0d/%b exp 0/0", drop_cnt, overflow); end
      total++; if (halted !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_fsm got %b/%b exp 0/0", halted, done); end
      total++; if (trace_instr !== 32'd0 || trace_pc !== 64'd0 || trace_seq !== 64'd0) begin bad++; $display("FAIL rst_data got %h/%h/%h exp 0", trace_instr, trace_pc, trace_seq); end
   endtask

   task automatic test_single();
      trace_ready = 1'b1;
      set_commit(32'h00000013, 64'h80000000, 64'h80000004);
      tick();
      commit = 1'b0;
      total++; if (trace_valid !== 1'b1 || level !== 4'd1) begin bad++; $display("FAIL single_valid got %b/%0d exp 1/1", trace_valid, level); end
      total++; if (trace_seq !== 64'd0 || trace_jump !== 1'b0) begin bad++; $display("FAIL single_seq got %0d/%b exp 0/0", trace_seq, trace_jump); end
      total++; if (trace_instr !== 32'h13 || trace_pc !== 64'h80000004 || trace_pre_pc !== 64'h80000000) begin bad++; $display("FAIL single_data got %h/%h/%h exp 13/80000004/80000000", trace_instr, trace_pc, trace_pre_pc); end
      tick();
      total++; if (trace_valid !== 1'b0 || commit_cnt !== 64'd1) begin bad++; $display("FAIL single_pop got %b/%0d exp 0/1", trace_valid, commit_cnt); end
      total++; if (trace_pc !== 64'd0) begin bad++; $display("FAIL single_empty_data got %h exp 0", trace_pc); end
   endtask

   task automatic test_jump();
      trace_ready = 1'b0;
      set_commit(32'h0000006f, 64'h80000010, 64'h80000100);
      tick();
      commit = 1'b0;
      total++; if (trace_jump !== 1'b1 || trace_seq !== 64'd1) begin bad++; $display("FAIL jump_taken got %b/%0d exp 1/1", trace_jump, trace_seq); end
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      set_commit(32'h00000013, 64'hFFFFFFFFFFFFFFFC, 64'h0);
      tick();
      commit = 1'b0;
      total++; if (trace_jump !== 1'b0 || trace_seq !== 64'd2) begin bad++; $display("FAIL jump_wrap got %b/%0d exp 0/2", trace_jump, trace_seq); end
      trace_ready = 1'b1;
      tick();
      total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL jump_drain got %b exp 0", trace_valid); end
   endtask

   task automatic test_overflow_and_full_pushpop();
      logic [63:0] expSeq [8];
      logic [31:0] expIns [8];
      expSeq = '{64'd5, 64'd6, 64'd7, 64'd10, 64'd11, 64'd12, 64'd13, 64'd14};
      expIns = '{32'd5, 32'd6, 32'd7, 32'd100, 32'd101, 32'd102, 32'd103, 32'd104};
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_commit(32'(i), 64'h1000 + 64'(4 * i), 64'h1004 + 64'(4 * i));
         tick();
      end
      commit = 1'b0;
      total++; if (level !== 4'd8 || drop_cnt !== 32'd2) begin bad++; $display("FAIL ovf_level got %0d/%0d exp 8/2", level, drop_cnt); end
      total++; if (overflow !== 1'b1 || commit_cnt !== 64'd10) begin bad++; $display("FAIL ovf_flag got %b/%0d exp 1/10", overflow, commit_cnt); end
      tick();
      total++; if (trace_seq !== 64'd0 || trace_instr !== 32'd0 || trace_pc !== 64'h1004) begin bad++; $display("FAIL ovf_hold got %0d/%h/%h exp 0/0/1004", trace_seq, trace_instr, trace_pc); end
      trace_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_commit(32'(100 + k), 64'h2000, 64'h2004);
         total++; if (trace_seq !== 64'(k) || trace_instr !== 32'(k)) begin bad++; $display("FAIL pushpop_head%0d got %0d/%0d exp %0d", k, trace_seq, trace_instr, k); end
         tick();
         total++; if (level !== 4'd8 || drop_cnt !== 32'd2) begin bad++; $display("FAIL pushpop_level%0d got %0d/%0d exp 8/2", k, level, drop_cnt); end
      end
      commit = 1'b0;
      total++; if (commit_cnt !== 64'd15) begin bad++; $display("FAIL pushpop_cnt got %0d exp 15", commit_cnt); end
      for (int k = 0; k < 8; k++) begin
         total++; if (trace_valid !== 1'b1 || trace_seq !== expSeq[k] || trace_instr !== expIns[k]) begin bad++; $display("FAIL drain%0d got %b/%0d/%0d exp 1/%0d/%0d", k, trace_valid, trace_seq, trace_instr, expSeq[k], expIns[k]); end
         tick();
      end
      total++; if (trace_valid !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL drain_empty got %b/%0d exp 0/0", trace_valid, level); end
   endtask

   task automatic test_ebreak();
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_commit(32'h13, 64'h100 + 64'(4 * i), 64'h104 + 64'(4 * i));
         tick();
      end
      set_commit(32'h00100073, 64'h10c, 64'h110);
      tick();
      total++; if (halted !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ebreak_halt got %b/%b exp 1/0", halted, done); end
      for (int i = 0; i < 2; i++) begin
         set_commit(32'h13, 64'h200, 64'h204);
         tick();
      end
      commit = 1'b0;
      total++; if (level !== 4'd4 || commit_cnt !== 64'd4 || drop_cnt !== 32'd0) begin bad++; $display("FAIL ebreak_ignore got %0d/%0d/%0d exp 4/4/0", level, commit_cnt, drop_cnt); end
      trace_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (done !== 1'b0 || trace_seq !== 64'(k)) begin bad++; $display("FAIL ebreak_pop%0d got %b/%0d exp 0/%0d", k, done, trace_seq, k); end
         tick();
      end
      total++; if (done !== 1'b1 || halted !== 1'b1 || trace_valid !== 1'b0) begin bad++; $display("FAIL ebreak_done got %b/%b/%b exp 1/1/0", done, halted, trace_valid); end
      set_commit(32'h13, 64'h300, 64'h304);
      tick();
      commit = 1'b0;
      total++; if (done !== 1'b1 || level !== 4'd0 || commit_cnt !== 64'd4) begin bad++; $display("FAIL done_terminal got %b/%0d/%0d exp 1/0/4", done, level, commit_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      trace_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_commit(32'h13, 64'h400, 64'h404);
         tick();
      end
      commit = 1'b0;
      trace_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      trace_ready = 1'b0;
      total++; if (level !== 4'd5 || overflow !== 1'b1) begin bad++; $display("FAIL mid_pre got %0d/%b exp 5/1", level, overflow); end
      rst = 1'b1;
      set_commit(32'h13, 64'h500, 64'h504);
      tick();
      rst = 1'b0; commit = 1'b0;
      total++; if (level !== 4'd0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL mid_rst got %0d/%b/%b exp 0/0/0", level, trace_valid, overflow); end
      total++; if (commit_cnt !== 64'd0 || drop_cnt !== 32'd0 || halted !== 1'b0 || trace_seq !== 64'd0) begin bad++; $display("FAIL mid_cnts got %0d/%0d/%b/%0d exp 0", commit_cnt, drop_cnt, halted, trace_seq); end
      set_commit(32'h33, 64'h600, 64'h604);
      tick();
      commit = 1'b0;
      total++; if (trace_valid !== 1'b1 || trace_seq !== 64'd0 || trace_instr !== 32'h33 || level !== 4'd1) begin bad++; $display("FAIL mid_resume got %b/%0d/%h/%0d exp 1/0/33/1", trace_valid, trace_seq, trace_instr, level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_jump();
      test_overflow_and_full_pushpop();
      test_ebreak();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
